// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit handshake bundle: imem request/response, redirect, and decode delivery.
// master = fetch unit side, slave = surrounding memory/decode/branch side.
interface instruction_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the PC, issues credit-limited word fetches, buffers {pc,word} for decode; response at N shows at N+1.
// Backpressure: requests stop once buffered + outstanding reach FIFO_DEPTH. `FETCH_PERF_EN adds fetch/stall counters.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  instruction_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              fetch_count,
  output logic [31:0]              stall_count
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t        buf_q [FIFO_DEPTH];
  logic [31:0]   aq [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, aq_rd, aq_wr;
  logic [CW-1:0] count, outstanding, drop;
  logic [31:0]   pc;

  logic [CW:0]   credit_sum;
  logic          req_valid, req_fire, rsp_live, push, pop, valid;
  entry_t        head;

  always_comb begin
    credit_sum = {1'b0, count} + {1'b0, outstanding};
    valid      = (count != '0);
    head       = buf_q[rd_ptr];
    // Requests are held off during a redirect so nothing stale is issued that cycle.
    req_valid  = reset_n && !bus.redirect_valid && (credit_sum < DEPTH_L);
    req_fire   = req_valid && bus.imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored entirely.
    rsp_live   = bus.imem_rsp_valid && (outstanding != '0);
    push       = rsp_live && (drop == '0) && !bus.redirect_valid;
    pop        = valid && bus.inst_ready && !bus.redirect_valid;

    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = pc;
    bus.inst_valid     = valid;
    bus.instruction    = valid ? head.data : 32'h0;
    bus.inst_pc        = valid ? head.pc   : 32'h0;
  end

  // PC, outstanding/drop accounting and the in-flight address queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= PC_INIT;
      outstanding <= '0;
      drop        <= '0;
      aq_rd       <= '0;
      aq_wr       <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) aq[i] <= 32'h0;
    end else begin
      if (req_fire) begin
        aq[aq_wr] <= pc;
        aq_wr     <= aq_wr + PW'(1);
      end
      if (rsp_live) aq_rd <= aq_rd + PW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_live);

      if (bus.redirect_valid) begin
        pc   <= bus.redirect_pc & ~32'h3;
        drop <= outstanding - CW'(rsp_live);
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (rsp_live && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  // Fetch buffer; a redirect empties it in one cycle and wins over push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) buf_q[i] <= '0;
    end else if (bus.redirect_valid) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= '{pc: aq[aq_rd], data: bus.imem_rsp_data};
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      fetch_count <= fetch_count + 32'(pop);
      stall_count <= stall_count + 32'(valid && !bus.inst_ready);
    end
  end
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front-end stage directly upstream of the instruction decoder. It owns the program counter (PC), issues word fetches to instruction memory over a valid/ready request channel, and accepts in-order responses. It buffers fetched words with their PC in a small FIFO and presents them to the decode stage over a valid/ready handshake. A redirect input (branch/jump/trap) restarts fetch at a new PC and squashes all younger work.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FIFO_DEPTH, 2, entries in the fetch buffer and the maximum number of outstanding requests (power of 2, ≥2).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous active-low reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_req_addr  output  32  word-aligned fetch address (bits [1:0] always 0).
imem_rsp_valid  input  1  response word valid; at most one per cycle, in request order, no earlier than 1 cycle after acceptance.
imem_rsp_data  input  32  response instruction word.
redirect_valid  input  1  restart fetch at redirect_pc.
redirect_pc  input  32  new PC; bits [1:0] are ignored and treated as 0.
inst_valid  output  1  instruction available to decode.
inst_ready  input  1  decode consumes the instruction this cycle.
instruction  output  32  instruction word for decode.
inst_pc  output  32  PC of the presented instruction.

Behaviour:
- Reset (async assert, sync-style release): pc=RESET_PC, FIFO empty, outstanding=0, drop=0. imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, instruction=0, inst_pc=0.
- Credit rule: imem_req_valid=1 iff !redirect_valid && (fifo_count + outstanding) < FIFO_DEPTH. imem_req_addr=pc, driven as a registered value.
- Request handshake: on imem_req_valid && imem_req_ready, increment outstanding and set pc=pc+4. The PC wraps modulo 2^32 (32'hFFFF_FFFC → 0). No request may be issued in the cycle a redirect is sampled.
- Response: on imem_rsp_valid, decrement outstanding. If drop>0, decrement drop and discard the data. Otherwise push {pc_of_request, data} into the FIFO. The PC of each request travels in a FIFO_DEPTH-deep address queue. Credit guarantees that a push never overflows.
- Decode handshake: inst_valid = FIFO non-empty. instruction and inst_pc come from the FIFO head. Pop on inst_valid && inst_ready. A push and a pop in the same cycle leave the count unchanged. Data must be stable while inst_valid && !inst_ready.
- Latency: with an empty FIFO, a response at cycle N gives inst_valid=1 at N+1. Sustained throughput is 1 instruction/cycle with single-cycle memory and inst_ready held high.
- Redirect (highest priority):
  - Set pc={redirect_pc[31:2],2'b00} and flush the FIFO; inst_valid=0 next cycle.
  - Set drop = outstanding minus 1 if a response arrives in the same cycle (that response is discarded).
  - A request accepted in the same cycle cannot occur, because imem_req_valid is forced low.
  - A decode pop in the same cycle is ignored (flush wins).
  - Back-to-back redirects: the last one wins, and drop is recomputed each time.
- Responses with outstanding=0 are a protocol error. They are ignored, and the counters saturate at 0.
- Reset mid-operation: all state clears immediately and in-flight responses are forgotten. Memory is reset by the same reset_n.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds output ports fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on each decode pop (delivered instruction).
  - stall_count increments each cycle with inst_valid && !inst_ready.
  - Both counters wrap at 2^32.
- Undefined: neither the ports nor the counters exist.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning addr^32'hA5A5_0000, inst_ready=1 → requests 0x0,0x4,0x8…; inst_pc/instruction pairs 0x0/0xA5A5_0000, 0x4/0xA5A5_0004, one per cycle after 2-cycle startup.
- inst_ready=0 for 10 cycles → after 2 requests imem_req_valid drops. instruction holds 0xA5A5_0000 with inst_pc 0x0 stable. On release, no word is lost or duplicated.
- Redirect to 32'h0000_1003 with 2 outstanding → next request addr 0x1000. The 2 stale responses are discarded. The first delivered inst_pc is 0x1000.
- Redirect in the same cycle as a response and an inst_ready pop → FIFO empty next cycle. Only the remaining outstanding response is dropped.
- RESET_PC=32'hFFFF_FFF8 → fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- reset_n asserted mid-stream with 2 outstanding → all outputs return to reset values asynchronously. After release, fetch restarts at RESET_PC. With FETCH_PERF_EN, counters read 0, then fetch_count=5 after 5 pops.
